key_expander: RTL
=================

Name: key_expander

Overview:
- Parametrised successor to the fixed round-key generator.
- Expands an AES-128, AES-192 or AES-256 cipher key into Nr+1 round keys, one 32-bit schedule word per cycle.
- Packs every 4 words into a 128-bit round key and writes it into the round-key RAM via a write port.
- Optional inverse mode emits the equivalent-inverse-cipher schedule in decryption read order, so the decrypt datapath needs no separate key pass.

Parameters:
KEY_BITS, 256, width of key input; must be 256.
ROUND_KEY_BITS, 128, width of rk_data; must be 128.
ADDR_W, 4, round-key RAM address width; must be >= 4 (Nr max 14).

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  one-cycle request; sampled only in IDLE
key_len  in  2  0=AES-128 (Nk=4,Nr=10), 1=AES-192 (Nk=6,Nr=12), 2=AES-256 (Nk=8,Nr=14), 3=illegal
inv_mode  in  1  1=equivalent inverse schedule
key  in  KEY_BITS  key word j at key[32j+:32], byte 0 of word at [7:0]; unused upper words ignored
busy  out  1  expansion in progress
done  out  1  one-cycle pulse, schedule complete
err  out  1  one-cycle pulse, start with key_len=3
rounds  out  ADDR_W  Nr of last accepted job; holds after done
rk_we  out  1  round-key write strobe
rk_addr  out  ADDR_W  round-key index
rk_data  out  ROUND_KEY_BITS  round key; word k at [32k+:32]

Behaviour:
- Reset values: busy=0, done=0, err=0, rk_we=0, rk_addr=0, rk_data=0, rounds=0. Internal state → IDLE, word counter=0, rcon index=0.
- Clocking: all outputs registered. Reset wins over every other input in the same cycle.
- IDLE:
  - start with key_len in 0..2: latch key, key_len, inv_mode into registers; go to EXPAND.
  - start with key_len=3: err=1 for one cycle, stay IDLE, no writes.
- EXPAND, word i = 0..4(Nr+1)-1, one per cycle:
  - i<Nk: w[i] = key word i.
  - Otherwise temp = w[i-1].
    - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {24'h0, rcon[i/Nk]}. RotWord moves byte 0 to byte 3. rcon = 01,02,04,08,10,20,40,80,1B,36.
    - Else if Nk==8 and i mod 8 == 4: temp = SubWord(temp).
    - w[i] = w[i-Nk] ^ temp.
  - Sliding window: 8-word shift register holding the last Nk words.
- Packing: after word 4r+3, next cycle rk_we=1, rk_data={w[4r+3],w[4r+2],w[4r+1],w[4r]}.
  - inv_mode=0: rk_addr=r.
  - inv_mode=1: rk_addr=Nr-r. For 1<=r<=Nr-1, rk_data = InvMixColumns applied per 32-bit column. r=0 and r=Nr are unmodified.
- Timing, start accepted at edge T0:
  - busy=1 from T0+1.
  - word i computed in cycle T0+1+i.
  - write r occurs in cycle T0+5+4r.
  - done=1 and busy=0 in cycle T0+6+4Nr. AES-128: done at T0+46; AES-192: T0+54; AES-256: T0+62.
  - rounds valid from T0+1.
- DONE: single-cycle state, returns to IDLE. A new start is accepted in the done cycle's successor, not during done.
- start while busy: ignored; latched key/mode unaffected; key/key_len/inv_mode changes mid-job have no effect.
- reset mid-job: rk_we=0 on the next cycle, no done. Partially written RAM contents are undefined to consumers.
- rk_we is never asserted outside EXPAND. Exactly Nr+1 writes per job, each address written once.

Test Plan:
- AES-128, inv_mode=0, key 2b7e151628aed2a6abf7158809cf4f3c (FIPS-197 byte order) → 11 writes, addr 0..10 at T0+5+4r. Addr 10 = round key d014f9a8c9ee2589e13f0cc8b6630ca6. done at T0+46, busy low same cycle.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → 13 writes, last word w51 = 01002202, done at T0+54.
- AES-256, key 603deb10…0914dff4 → 15 writes, w59 = 706c631e. Exercises the i mod 8 == 4 SubWord path; done at T0+62.
- AES-128, inv_mode=1 → addr 0 = d014f9a8…0ca6, addr 10 = original key. Addr 1..9 = InvMixColumns of forward keys 9..1 (compare to golden model).
- Boundaries:
  - start with key_len=3 → err pulse, no rk_we, busy stays 0.
  - start pulsed during busy → no effect on writes or timing.
  - reset at T0+20 → rk_we=0 from T0+21, no done; a fresh job then completes correctly.
- Back-to-back: second start at the cycle after done → second job's timing is identical to the first, counting from its own T0.

Source files
------------

// File: rtl/key_expander.sv
// key_expander: AES-128/192/256 key schedule, one 32-bit word per cycle,
// packed four words at a time into 128-bit round keys for the round-key RAM.
`timescale 1ns/1ps
module key_expander #(
    parameter int KEY_BITS       = 256,
    parameter int ROUND_KEY_BITS = 128,
    parameter int ADDR_W         = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [1:0]                key_len,
    input  logic                      inv_mode,
    input  logic [KEY_BITS-1:0]       key,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [ADDR_W-1:0]         rounds,
    output logic                      rk_we,
    output logic [ADDR_W-1:0]         rk_addr,
    output logic [ROUND_KEY_BITS-1:0] rk_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXPAND,
        S_DONE
    } state_t;

    // Byte x of the S-box sits at bits [8*(255-x) +: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]),
                sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // InvMixColumns on one column; byte 0 of the word is row 0.
    function automatic logic [31:0] imc_col(input logic [31:0] c);
        logic [7:0] a, x2, x4, x8;
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int k = 0; k < 4; k++) begin
            a     = c[8*k +: 8];
            x2    = xt(a);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[k] = x8 ^ a;
            mb[k] = x8 ^ x2 ^ a;
            md[k] = x8 ^ x4 ^ a;
            me[k] = x8 ^ x4 ^ x2;
        end
        imc_col[7:0]   = me[0] ^ mb[1] ^ md[2] ^ m9[3];
        imc_col[15:8]  = m9[0] ^ me[1] ^ mb[2] ^ md[3];
        imc_col[23:16] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
        imc_col[31:24] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    endfunction

    function automatic logic [ROUND_KEY_BITS-1:0] imc_rk(
        input logic [ROUND_KEY_BITS-1:0] rk
    );
        for (int k = 0; k < ROUND_KEY_BITS / 32; k++)
            imc_rk[32*k +: 32] = imc_col(rk[32*k +: 32]);
    endfunction

    state_t              state;
    logic [KEY_BITS-1:0] key_q;
    logic                inv_q;
    logic [2:0]          nk_m1;
    logic [5:0]          i_cnt;
    logic [2:0]          mod_cnt;
    logic [3:0]          rcon_idx;
    logic [31:0]         win [8];

    logic [31:0]               w_prev, w_old, sub_in, sub_out;
    logic [31:0]               key_w, w_new;
    logic [3:0]                rk_r;
    logic                      inner;
    logic [5:0]                end_i;
    logic [ROUND_KEY_BITS-1:0] pack, rk_next;
    logic [ADDR_W-1:0]         addr_next;

    // Next schedule word from the latched key or the sliding window
    always_comb begin
        w_prev  = win[0];
        w_old   = win[nk_m1];
        sub_in  = (mod_cnt == 3'd0) ? {w_prev[7:0], w_prev[31:8]}
                                    : w_prev;
        sub_out = sub_word(sub_in);
        key_w   = key_q[{i_cnt[2:0], 5'b00000} +: 32];
        if (i_cnt <= {3'b000, nk_m1})
            w_new = key_w;
        else if (mod_cnt == 3'd0)
            w_new = w_old ^ sub_out ^ {24'h0, rcon(rcon_idx)};
        else if (nk_m1 == 3'd7 && mod_cnt == 3'd4)
            w_new = w_old ^ sub_out;
        else
            w_new = w_old ^ w_prev;
    end

    // Round-key packing, inverse-order address and InvMixColumns
    always_comb begin
        rk_r      = i_cnt[5:2];
        end_i     = {rounds[3:0], 2'b00} + 6'd4;
        pack      = {w_new, win[0], win[1], win[2]};
        inner     = (rk_r != 4'd0) && (rk_r != rounds[3:0]);
        rk_next   = (inv_q && inner) ? imc_rk(pack) : pack;
        addr_next = inv_q ? rounds - ADDR_W'(rk_r) : ADDR_W'(rk_r);
    end

    // Control FSM, schedule window and registered write port
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rounds   <= '0;
            rk_we    <= 1'b0;
            rk_addr  <= '0;
            rk_data  <= '0;
            key_q    <= '0;
            inv_q    <= 1'b0;
            nk_m1    <= 3'd0;
            i_cnt    <= 6'd0;
            mod_cnt  <= 3'd0;
            rcon_idx <= 4'd0;
            for (int k = 0; k < 8; k++)
                win[k] <= 32'h0;
        end else begin
            done  <= 1'b0;
            err   <= 1'b0;
            rk_we <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        if (key_len == 2'd3) begin
                            err <= 1'b1;
                        end else begin
                            state    <= S_EXPAND;
                            busy     <= 1'b1;
                            key_q    <= key;
                            inv_q    <= inv_mode;
                            i_cnt    <= 6'd0;
                            mod_cnt  <= 3'd0;
                            rcon_idx <= 4'd0;
                            unique case (key_len)
                                2'd0: begin
                                    nk_m1  <= 3'd3;
                                    rounds <= ADDR_W'(10);
                                end
                                2'd1: begin
                                    nk_m1  <= 3'd5;
                                    rounds <= ADDR_W'(12);
                                end
                                default: begin
                                    nk_m1  <= 3'd7;
                                    rounds <= ADDR_W'(14);
                                end
                            endcase
                        end
                    end
                end
                S_EXPAND: begin
                    if (i_cnt == end_i) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        win[0] <= w_new;
                        for (int k = 1; k < 8; k++)
                            win[k] <= win[k-1];
                        i_cnt <= i_cnt + 6'd1;
                        if (mod_cnt == nk_m1) begin
                            mod_cnt  <= 3'd0;
                            rcon_idx <= rcon_idx + 4'd1;
                        end else begin
                            mod_cnt <= mod_cnt + 3'd1;
                        end
                        if (i_cnt[1:0] == 2'b11) begin
                            rk_we   <= 1'b1;
                            rk_addr <= addr_next;
                            rk_data <= rk_next;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
